// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the external SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned SRAM_ADDR_W = 19;
  localparam int unsigned SRAM_DATA_W = 8;
  localparam int unsigned CNT_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WS,
    ST_WP,
    ST_WH
  } arb_state_t;

  // Round-robin successor over channels 1..nch-1 (channel 0 is never in the rotation).
  function automatic int unsigned rr_next(input int unsigned win, input int unsigned nch);
    return (win + 1 >= nch) ? 1 : win + 1;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Client-side request/response bus of the SRAM arbiter, one lane per channel.
interface sram_arbiter_if #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
);
  logic [NCH-1:0]        req;
  logic [NCH-1:0]        we;
  logic [NCH*ADDR_W-1:0] addr;
  logic [NCH*DATA_W-1:0] wdata;
  logic [NCH-1:0]        gnt;
  logic [NCH-1:0]        rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  busy;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, busy);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, busy);
endinterface

// File: rtl/sram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
// Only present when SRAM_ARB_RR_EN is defined.
`ifdef SRAM_ARB_RR_EN
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  // Scan from farthest to nearest so the closest requester to ptr_i wins.
  always_comb begin
    gnt_o = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_i) + k;
      if (idx >= int'(N)) idx = idx - int'(N);
      if (req_i[PW'(idx)]) begin
        gnt_o            = '0;
        gnt_o[PW'(idx)]  = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/sram_arbiter.sv
// N-channel arbiter and timing FSM for an external async SRAM.
// Define SRAM_ARB_RR_EN for round-robin among ch1..NCH-1; otherwise fixed priority.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned ADDR_W   = SRAM_ADDR_W,
  parameter int unsigned DATA_W   = SRAM_DATA_W,
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned WR_SETUP = 1,
  parameter int unsigned WR_PULSE = 2
) (
  input  logic              clk28,
  input  logic              rst,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] va,
  input  logic [DATA_W-1:0] vd_i,
  output logic [DATA_W-1:0] vd_o,
  output logic              vd_oe,
  output logic              n_vrd,
  output logic              n_vwr
);

  localparam int unsigned      IDX_W   = $clog2(NCH);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'((WR_SETUP > 0) ? WR_SETUP - 1 : 0);
  localparam logic [CNT_W-1:0] WP_LOAD = CNT_W'(WR_PULSE - 1);

  arb_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NCH-1:0]    gnt_q, rvalid_q, rd_oh_q;
  logic [DATA_W-1:0] rdata_q, vd_o_q;
  logic [ADDR_W-1:0] va_q;
  logic              vd_oe_q, n_vrd_q, n_vwr_q;

  logic [NCH-1:0]    req_hi_c, hi_oh_c, win_oh_c;
  logic              win_vld_c, fire_c, sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  assign req_hi_c  = {bus.req[NCH-1:1], 1'b0};
  assign win_vld_c = |bus.req;
  assign win_oh_c  = bus.req[0] ? NCH'(1) : hi_oh_c;
  assign fire_c    = (state_q == ST_IDLE) && win_vld_c;

`ifdef SRAM_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] win_idx_c;

  rr_arbiter #(.N(NCH)) u_rr (
    .req_i (req_hi_c),
    .ptr_i (ptr_q),
    .gnt_o (hi_oh_c)
  );

  always_comb begin
    win_idx_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (win_oh_c[i]) win_idx_c = IDX_W'(i);
    end
  end

  // Rotation only moves on grants to ch1..NCH-1; ch0 wins outside the rotation.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      ptr_q <= IDX_W'(1);
    end else if (fire_c && (win_idx_c != '0)) begin
      ptr_q <= IDX_W'(rr_next(32'(win_idx_c), NCH));
    end
  end
`else
  always_comb begin
    hi_oh_c = '0;
    for (int i = int'(NCH) - 1; i >= 1; i--) begin
      if (req_hi_c[i]) begin
        hi_oh_c    = '0;
        hi_oh_c[i] = 1'b1;
      end
    end
  end
`endif

  // Winning channel's request payload.
  always_comb begin
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    sel_we_c    = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (win_oh_c[i]) begin
        sel_addr_c  = bus.addr[i*ADDR_W +: ADDR_W];
        sel_wdata_c = bus.wdata[i*DATA_W +: DATA_W];
        sel_we_c    = bus.we[i];
      end
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rd_oh_q  <= '0;
      rdata_q  <= '0;
      va_q     <= '0;
      vd_o_q   <= '0;
      vd_oe_q  <= 1'b0;
      n_vrd_q  <= 1'b1;
      n_vwr_q  <= 1'b1;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (fire_c) begin
            gnt_q  <= win_oh_c;
            va_q   <= sel_addr_c;
            vd_o_q <= sel_wdata_c;
            if (sel_we_c) begin
              vd_oe_q <= 1'b1;
              if (WR_SETUP == 0) begin
                state_q <= ST_WP;
                n_vwr_q <= 1'b0;
                cnt_q   <= WP_LOAD;
              end else begin
                state_q <= ST_WS;
                cnt_q   <= WS_LOAD;
              end
            end else begin
              state_q <= ST_RD;
              n_vrd_q <= 1'b0;
              cnt_q   <= RD_LOAD;
              rd_oh_q <= win_oh_c;
            end
          end
        end
        ST_RD: begin
          if (cnt_q == '0) begin
            n_vrd_q  <= 1'b1;
            rdata_q  <= vd_i;
            rvalid_q <= rd_oh_q;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WS: begin
          if (cnt_q == '0) begin
            n_vwr_q <= 1'b0;
            cnt_q   <= WP_LOAD;
            state_q <= ST_WP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WP: begin
          if (cnt_q == '0) begin
            n_vwr_q <= 1'b1;
            state_q <= ST_WH;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WH: begin
          vd_oe_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign va         = va_q;
  assign vd_o       = vd_o_q;
  assign vd_oe      = vd_oe_q;
  assign n_vrd      = n_vrd_q;
  assign n_vwr      = n_vwr_q;

endmodule
